// File: rtl/hawk_axi_line_mst_if.sv
// Bundle of every signal between the line-request client, the line master and
// the AXI slave. Clock and reset stay outside as plain ports.
//   req_*          : line request (valid/ready, write flag, address, 512-bit data/strobes)
//   rsp_*          : line completion (valid/ready, 512-bit read data, error flag)
//   axi_aw/w/b/ar/r: AXI4 channels, 256-bit data, two-beat INCR bursts
//   *_done_cnt     : saturating completed write/read counters
// master modport is the line master's view; slave modport is the environment's view.
interface hawk_axi_line_mst_if #(
    parameter int unsigned ID_W = 6
);
    // line request / response
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [63:0]       req_addr;
    logic [511:0]      req_wdata;
    logic [63:0]       req_wstrb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [511:0]      rsp_rdata;
    logic              rsp_err;

    // AXI write address / data / response
    logic [ID_W-1:0]   axi_awid;
    logic [63:0]       axi_awaddr;
    logic [7:0]        axi_awlen;
    logic [2:0]        axi_awsize;
    logic [1:0]        axi_awburst;
    logic              axi_awvalid;
    logic              axi_awready;
    logic [255:0]      axi_wdata;
    logic [31:0]       axi_wstrb;
    logic              axi_wlast;
    logic              axi_wvalid;
    logic              axi_wready;
    logic [ID_W-1:0]   axi_bid;
    logic [1:0]        axi_bresp;
    logic              axi_buser;
    logic              axi_bvalid;
    logic              axi_bready;

    // AXI read address / data
    logic [ID_W-1:0]   axi_arid;
    logic [63:0]       axi_araddr;
    logic [7:0]        axi_arlen;
    logic [2:0]        axi_arsize;
    logic [1:0]        axi_arburst;
    logic              axi_arvalid;
    logic              axi_arready;
    logic [ID_W-1:0]   axi_rid;
    logic [255:0]      axi_rdata;
    logic [1:0]        axi_rresp;
    logic              axi_ruser;
    logic              axi_rlast;
    logic              axi_rvalid;
    logic              axi_rready;

    // completion counters
    logic [15:0]       wr_done_cnt;
    logic [15:0]       rd_done_cnt;

    modport master (
        input  req_valid, req_wr, req_addr, req_wdata, req_wstrb,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
        input  axi_awready,
        output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        input  axi_wready,
        input  axi_bid, axi_bresp, axi_buser, axi_bvalid,
        output axi_bready,
        output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid,
        input  axi_arready,
        input  axi_rid, axi_rdata, axi_rresp, axi_ruser, axi_rlast, axi_rvalid,
        output axi_rready,
        output wr_done_cnt, rd_done_cnt
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_wdata, req_wstrb,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
        output axi_awready,
        input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        output axi_wready,
        output axi_bid, axi_bresp, axi_buser, axi_bvalid,
        input  axi_bready,
        input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid,
        output axi_arready,
        output axi_rid, axi_rdata, axi_rresp, axi_ruser, axi_rlast, axi_rvalid,
        input  axi_rready,
        input  wr_done_cnt, rd_done_cnt
    );
endinterface

// File: rtl/hawk_axi_line_mst.sv
// Single-outstanding AXI4 master that moves one 64-byte cache line per request
// as a two-beat, 256-bit INCR burst, and returns a completion with read data and
// an error flag (bad response code, unexpected ID or misplaced rlast).
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset; abandons any in-flight transaction
//   bus  : hawk_axi_line_mst_if.master (request, response, AXI channels, counters)
module hawk_axi_line_mst #(
    parameter int unsigned    ID_W   = 6,
    parameter logic [ID_W-1:0] MST_ID = ID_W'(1)
) (
    input  logic                     clk,
    input  logic                     rst,
    hawk_axi_line_mst_if.master      bus
);

    localparam int unsigned LINE_W = 512;
    localparam int unsigned BEAT_W = 256;
    localparam int unsigned STRB_W = 64;
    localparam int unsigned TAG_W  = 58;
    localparam int unsigned CNT_W  = 16;

    localparam logic [7:0] AXI_LEN   = 8'd1;
    localparam logic [2:0] AXI_SIZE  = 3'b101;
    localparam logic [1:0] AXI_BURST = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_AR,
        S_R,
        S_RSP
    } state_e;

    state_e                state_q, state_d;

    // captured request
    logic                  wr_q, wr_d;
    logic [TAG_W-1:0]      line_q, line_d;
    logic [LINE_W-1:0]     wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;

    // burst progress and completion payload
    logic                  wbeat_q, wbeat_d;
    logic                  rbeat_q, rbeat_d;
    logic [LINE_W-1:0]     rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;

    // registered handshake outputs
    logic                  req_ready_q, req_ready_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  wlast_q, wlast_d;
    logic [BEAT_W-1:0]     axi_wdata_q, axi_wdata_d;
    logic [BEAT_W/8-1:0]   axi_wstrb_q, axi_wstrb_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  rsp_valid_q, rsp_valid_d;

    // handshakes as seen at the coming edge
    logic req_fire_c, aw_fire_c, w_fire_c, b_fire_c, ar_fire_c, r_fire_c, rsp_fire_c;

    assign req_fire_c = bus.req_valid  & req_ready_q;
    assign aw_fire_c  = awvalid_q      & bus.axi_awready;
    assign w_fire_c   = wvalid_q       & bus.axi_wready;
    assign b_fire_c   = bus.axi_bvalid & bready_q;
    assign ar_fire_c  = arvalid_q      & bus.axi_arready;
    assign r_fire_c   = bus.axi_rvalid & rready_q;
    assign rsp_fire_c = rsp_valid_q    & bus.rsp_ready;

    // Sideband user bits and sub-line address bits carry no meaning here.
    logic unused_sink_c;
    assign unused_sink_c = ^{bus.axi_buser, bus.axi_ruser, bus.req_addr[5:0]};

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_q        <= 1'b0;
            line_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            wbeat_q     <= 1'b0;
            rbeat_q     <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            req_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            wlast_q     <= 1'b0;
            axi_wdata_q <= '0;
            axi_wstrb_q <= '0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            line_q      <= line_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            wbeat_q     <= wbeat_d;
            rbeat_q     <= rbeat_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            req_ready_q <= req_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            wlast_q     <= wlast_d;
            axi_wdata_q <= axi_wdata_d;
            axi_wstrb_q <= axi_wstrb_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Next state, datapath updates, and output flops decoded from the next state
    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        line_d   = line_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        wbeat_d  = wbeat_q;
        rbeat_d  = rbeat_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (req_fire_c) begin
                    wr_d    = bus.req_wr;
                    line_d  = bus.req_addr[63:6];
                    wdata_d = bus.req_wdata;
                    wstrb_d = bus.req_wstrb;
                    wbeat_d = 1'b0;
                    rbeat_d = 1'b0;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = bus.req_wr ? S_AW : S_AR;
                end
            end
            S_AW: begin
                if (aw_fire_c) begin
                    state_d = S_W;
                end
            end
            S_W: begin
                if (w_fire_c) begin
                    wbeat_d = 1'b1;
                    if (wbeat_q) begin
                        state_d = S_B;
                    end
                end
            end
            S_B: begin
                if (b_fire_c) begin
                    err_d   = (bus.axi_bresp != 2'b00) | (bus.axi_bid != MST_ID);
                    state_d = S_RSP;
                end
            end
            S_AR: begin
                if (ar_fire_c) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                if (r_fire_c) begin
                    if (rbeat_q) begin
                        rdata_d[LINE_W-1:BEAT_W] = bus.axi_rdata;
                        state_d                  = S_RSP;
                    end else begin
                        rdata_d[BEAT_W-1:0] = bus.axi_rdata;
                    end
                    // rlast must mark exactly the second beat
                    err_d   = err_q | (bus.axi_rresp != 2'b00) | (bus.axi_rid != MST_ID)
                            | (bus.axi_rlast != rbeat_q);
                    rbeat_d = 1'b1;
                end
            end
            S_RSP: begin
                if (rsp_fire_c) begin
                    state_d = S_IDLE;
                    if (wr_q) begin
                        wr_cnt_d = (wr_cnt_q == 16'hFFFF) ? wr_cnt_q : wr_cnt_q + 16'd1;
                    end else begin
                        rd_cnt_d = (rd_cnt_q == 16'hFFFF) ? rd_cnt_q : rd_cnt_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake outputs follow the state being entered so each leg adds one cycle.
        req_ready_d = (state_d == S_IDLE);
        awvalid_d   = (state_d == S_AW);
        wvalid_d    = (state_d == S_W);
        wlast_d     = (state_d == S_W) & wbeat_d;
        bready_d    = (state_d == S_B);
        arvalid_d   = (state_d == S_AR);
        rready_d    = (state_d == S_R);
        rsp_valid_d = (state_d == S_RSP);
        axi_wdata_d = '0;
        axi_wstrb_d = '0;
        if (state_d == S_W) begin
            axi_wdata_d = wbeat_d ? wdata_d[LINE_W-1:BEAT_W] : wdata_d[BEAT_W-1:0];
            axi_wstrb_d = wbeat_d ? wstrb_d[STRB_W-1:STRB_W/2] : wstrb_d[STRB_W/2-1:0];
        end
    end

    // request / response
    assign bus.req_ready   = req_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_err     = err_q;

    // write address / data / response
    assign bus.axi_awid    = MST_ID;
    assign bus.axi_awaddr  = {line_q, 6'b0};
    assign bus.axi_awlen   = AXI_LEN;
    assign bus.axi_awsize  = AXI_SIZE;
    assign bus.axi_awburst = AXI_BURST;
    assign bus.axi_awvalid = awvalid_q;
    assign bus.axi_wdata   = axi_wdata_q;
    assign bus.axi_wstrb   = axi_wstrb_q;
    assign bus.axi_wlast   = wlast_q;
    assign bus.axi_wvalid  = wvalid_q;
    assign bus.axi_bready  = bready_q;

    // read address / data
    assign bus.axi_arid    = MST_ID;
    assign bus.axi_araddr  = {line_q, 6'b0};
    assign bus.axi_arlen   = AXI_LEN;
    assign bus.axi_arsize  = AXI_SIZE;
    assign bus.axi_arburst = AXI_BURST;
    assign bus.axi_arvalid = arvalid_q;
    assign bus.axi_rready  = rready_q;

    assign bus.wr_done_cnt = wr_cnt_q;
    assign bus.rd_done_cnt = rd_cnt_q;

endmodule

// File: tb/tb_hawk_axi_line_mst.sv
// Directed bench for hawk_axi_line_mst: a reactive AXI slave with its own line
// memory, a reference line model plus response scoreboard in the stimulus thread.
module tb_hawk_axi_line_mst;

    localparam int unsigned    ID_W   = 6;
    localparam logic [ID_W-1:0] MST_ID = 6'd1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hawk_axi_line_mst_if #(.ID_W(ID_W)) bus ();

    hawk_axi_line_mst #(.ID_W(ID_W), .MST_ID(MST_ID)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- slave knobs and observations ----------------
    int              aw_left   = 0;
    bit              w_toggle  = 0;
    bit              w_hold_b1 = 0;
    bit              bid_bad   = 0;
    bit              rresp_bad = 0;
    bit              rlast_b0  = 0;

    int              aw_hi_cnt;
    int              w_beats;
    logic [63:0]     aw_addr_seen, ar_addr_seen;
    logic [7:0]      aw_len_seen, ar_len_seen;
    logic [2:0]      aw_size_seen;
    logic [1:0]      aw_burst_seen;
    logic [ID_W-1:0] aw_id_seen, ar_id_seen;

    logic [511:0] smem [logic [57:0]];
    bit           aw_ok, w_stalled, w_tg, b_pend, b_fire_prev, r_act, r_fire_prev;
    int           wbi, r_beat;
    logic [288:0] stall_snap;
    logic [511:0] w_line, r_line;
    logic [63:0]  w_strb;

    // Slave reacts on the falling edge; a handshake decided here fires at the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            bus.axi_awready = 1'b0;  bus.axi_wready  = 1'b0;  bus.axi_arready = 1'b0;
            bus.axi_bvalid  = 1'b0;  bus.axi_bid     = '0;    bus.axi_bresp   = 2'b00;
            bus.axi_buser   = 1'b0;  bus.axi_rvalid  = 1'b0;  bus.axi_rid     = '0;
            bus.axi_rdata   = '0;    bus.axi_rresp   = 2'b00; bus.axi_ruser   = 1'b0;
            bus.axi_rlast   = 1'b0;
            aw_ok = 0; w_stalled = 0; w_tg = 1; b_pend = 0; b_fire_prev = 0;
            r_act = 0; r_fire_prev = 0; wbi = 0; r_beat = 0;
        end else begin
            // B channel (before W so a response never precedes the last W handshake)
            if (b_fire_prev) begin
                bus.axi_bvalid = 1'b0;
                b_pend         = 0;
            end
            if (b_pend && !bus.axi_bvalid) begin
                bus.axi_bvalid = 1'b1;
                bus.axi_bid    = bid_bad ? MST_ID + ID_W'(1) : MST_ID;
                bus.axi_bresp  = 2'b00;
                bus.axi_buser  = 1'($urandom);
            end
            b_fire_prev = bus.axi_bvalid & bus.axi_bready;

            // AW channel
            if (bus.axi_awvalid) begin
                aw_hi_cnt++;
                if (aw_left > 0) begin
                    bus.axi_awready = 1'b0;
                    aw_left--;
                end else begin
                    bus.axi_awready = 1'b1;
                    aw_ok         = 1;
                    aw_addr_seen  = bus.axi_awaddr;
                    aw_len_seen   = bus.axi_awlen;
                    aw_size_seen  = bus.axi_awsize;
                    aw_burst_seen = bus.axi_awburst;
                    aw_id_seen    = bus.axi_awid;
                    wbi           = 0;
                end
            end else begin
                bus.axi_awready = 1'b0;
            end

            // W channel
            if (w_stalled) chk("wvalid_held", 512'(bus.axi_wvalid), 512'(1));
            if (bus.axi_wvalid) begin
                chk("w_after_aw", 512'(aw_ok), 512'(1));
                if (w_stalled)
                    chk("w_stable", 512'({bus.axi_wlast, bus.axi_wstrb, bus.axi_wdata}),
                        512'(stall_snap));
                w_tg = ~w_tg;
                bus.axi_wready = (w_toggle ? w_tg : 1'b1) & !(w_hold_b1 && wbi == 1);
                if (bus.axi_wready) begin
                    chk("wlast", 512'(bus.axi_wlast), 512'(wbi == 1));
                    if (wbi == 0) begin
                        w_line[255:0] = bus.axi_wdata;   w_strb[31:0]  = bus.axi_wstrb;
                    end else begin
                        w_line[511:256] = bus.axi_wdata; w_strb[63:32] = bus.axi_wstrb;
                    end
                    wbi++;
                    w_beats++;
                    w_stalled = 0;
                    if (bus.axi_wlast) begin
                        logic [511:0] l;
                        l = smem.exists(aw_addr_seen[63:6]) ? smem[aw_addr_seen[63:6]] : '0;
                        for (int i = 0; i < 64; i++)
                            if (w_strb[i]) l[i*8 +: 8] = w_line[i*8 +: 8];
                        smem[aw_addr_seen[63:6]] = l;
                        b_pend = 1;
                        aw_ok  = 0;
                    end
                end else begin
                    w_stalled  = 1;
                    stall_snap = {bus.axi_wlast, bus.axi_wstrb, bus.axi_wdata};
                end
            end else begin
                bus.axi_wready = 1'b0;
            end

            // R channel (before AR so data follows the address handshake)
            if (r_fire_prev) begin
                r_beat++;
                if (r_beat == 2) begin
                    bus.axi_rvalid = 1'b0;
                    r_act          = 0;
                end
            end
            if (r_act) begin
                bus.axi_rvalid = 1'b1;
                bus.axi_rid    = MST_ID;
                bus.axi_rdata  = (r_beat == 0) ? r_line[255:0] : r_line[511:256];
                bus.axi_rresp  = (rresp_bad && r_beat == 1) ? 2'b10 : 2'b00;
                bus.axi_rlast  = rlast_b0 ? 1'b1 : (r_beat == 1);
                bus.axi_ruser  = 1'($urandom);
            end
            r_fire_prev = bus.axi_rvalid & bus.axi_rready;

            // AR channel
            if (bus.axi_arvalid) begin
                bus.axi_arready = 1'b1;
                ar_addr_seen    = bus.axi_araddr;
                ar_len_seen     = bus.axi_arlen;
                ar_id_seen      = bus.axi_arid;
                r_line = smem.exists(bus.axi_araddr[63:6]) ? smem[bus.axi_araddr[63:6]] : '0;
                r_act  = 1;
                r_beat = 0;
            end else begin
                bus.axi_arready = 1'b0;
            end
        end
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct packed {
        logic         wr;
        logic         err;
        logic [511:0] rdata;
    } sb_t;

    sb_t          sb[$];
    logic [511:0] mmem [logic [57:0]];
    int           exp_wr = 0;
    int           exp_rd = 0;

    function automatic logic [511:0] pat(input int seed);
        logic [511:0] p;
        for (int i = 0; i < 16; i++) p[i*32 +: 32] = 32'(seed * 32'h0101_0101 + i * 32'h1111);
        return p;
    endfunction

    // Drive one request; expectation is pushed as the request goes out.
    task automatic send_req(input bit wr, input logic [63:0] addr, input logic [511:0] data,
                            input logic [63:0] strb, input bit exp_err);
        sb_t          it;
        logic [511:0] l;
        int           n;
        l = mmem.exists(addr[63:6]) ? mmem[addr[63:6]] : '0;
        if (wr) begin
            for (int i = 0; i < 64; i++) if (strb[i]) l[i*8 +: 8] = data[i*8 +: 8];
            mmem[addr[63:6]] = l;
            it.rdata = '0;
        end else begin
            it.rdata = l;
        end
        it.wr  = wr;
        it.err = exp_err;
        sb.push_back(it);
        aw_hi_cnt = 0;
        w_beats   = 0;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = data;
        bus.req_wstrb = strb;
        bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 100) begin @(negedge clk); n++; end
        chk("req_accept", 512'(bus.req_ready), 512'(1));
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("req_ready_busy", 512'(bus.req_ready), 512'(0));
        chk(wr ? "awvalid_lat" : "arvalid_lat",
            512'(wr ? bus.axi_awvalid : bus.axi_arvalid), 512'(1));
    endtask

    // Wait for the completion, compare against the scoreboard, optionally stall rsp_ready.
    task automatic get_rsp(input int stall);
        sb_t it;
        int  n;
        n = 0;
        while (!bus.rsp_valid && n < 200) begin @(negedge clk); n++; end
        chk("rsp_arrive", 512'(bus.rsp_valid), 512'(1));
        it = (sb.size() > 0) ? sb.pop_front() : '0;
        chk("rsp_rdata", bus.rsp_rdata, it.rdata);
        chk("rsp_err", 512'(bus.rsp_err), 512'(it.err));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("rsp_hold_valid", 512'(bus.rsp_valid), 512'(1));
            chk("rsp_hold_rdata", bus.rsp_rdata, it.rdata);
            chk("rsp_hold_err", 512'(bus.rsp_err), 512'(it.err));
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("rsp_drop", 512'(bus.rsp_valid), 512'(0));
        if (it.wr) exp_wr++; else exp_rd++;
        chk("wr_done_cnt", 512'(bus.wr_done_cnt), 512'(exp_wr));
        chk("rd_done_cnt", 512'(bus.rd_done_cnt), 512'(exp_rd));
    endtask

    task automatic chk_aw(input logic [63:0] addr, input int hi_cycles);
        chk("awaddr", 512'(aw_addr_seen), 512'({addr[63:6], 6'b0}));
        chk("awlen", 512'(aw_len_seen), 512'(8'd1));
        chk("awsize", 512'(aw_size_seen), 512'(3'b101));
        chk("awburst", 512'(aw_burst_seen), 512'(2'b01));
        chk("awid", 512'(aw_id_seen), 512'(MST_ID));
        chk("awvalid_cycles", 512'(aw_hi_cnt), 512'(hi_cycles));
        chk("w_beats", 512'(w_beats), 512'(2));
    endtask

    task automatic chk_ar(input logic [63:0] addr);
        chk("araddr", 512'(ar_addr_seen), 512'({addr[63:6], 6'b0}));
        chk("arlen", 512'(ar_len_seen), 512'(8'd1));
        chk("arid", 512'(ar_id_seen), 512'(MST_ID));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [511:0] p1, p2, p4;
        int           n;
        p1 = pat(7);
        p2 = pat(42);
        p4 = pat(99);
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0;   bus.req_wstrb = '0; bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_req_ready", 512'(bus.req_ready), 512'(0));
        chk("rst_valids", 512'({bus.axi_awvalid, bus.axi_wvalid, bus.axi_arvalid,
                                bus.axi_bready, bus.axi_rready, bus.rsp_valid}), 512'(0));
        chk("rst_rsp_err", 512'(bus.rsp_err), 512'(0));
        chk("rst_cnts", 512'({bus.wr_done_cnt, bus.rd_done_cnt}), 512'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("req_ready_after_rst", 512'(bus.req_ready), 512'(1));

        // full-line write, slave always ready
        send_req(1'b1, 64'h1000_0040, p1, {64{1'b1}}, 1'b0);
        get_rsp(0);
        chk_aw(64'h1000_0040, 1);

        // read it back
        send_req(1'b0, 64'h1000_0040, '0, '0, 1'b0);
        get_rsp(0);
        chk_ar(64'h1000_0040);

        // AW stalled 5 cycles, wready toggling, partial strobes
        aw_left  = 5;
        w_toggle = 1;
        send_req(1'b1, 64'h2000_0080, p2, 64'hF0F0_0000_FFFF_000F, 1'b0);
        get_rsp(0);
        chk_aw(64'h2000_0080, 6);
        w_toggle = 0;

        // read back with unaligned byte address
        send_req(1'b0, 64'h2000_00A5, '0, '0, 1'b0);
        get_rsp(0);
        chk_ar(64'h2000_00A5);

        // error response on beat 1
        rresp_bad = 1;
        send_req(1'b0, 64'h1000_0040, '0, '0, 1'b1);
        get_rsp(0);
        rresp_bad = 0;

        // rlast on beat 0
        rlast_b0 = 1;
        send_req(1'b0, 64'h1000_0040, '0, '0, 1'b1);
        get_rsp(0);
        rlast_b0 = 0;

        // wrong bid, response held 3 cycles
        bid_bad = 1;
        send_req(1'b1, 64'h4000_0000, p4, {64{1'b1}}, 1'b1);
        get_rsp(3);
        bid_bad = 0;

        // reset during the second W beat
        w_hold_b1 = 1;
        send_req(1'b1, 64'h3000_0000, p1, {64{1'b1}}, 1'b0);
        n = 0;
        while (!(bus.axi_wvalid && bus.axi_wlast) && n < 50) begin @(negedge clk); n++; end
        chk("w_beat1_reached", 512'(bus.axi_wvalid & bus.axi_wlast), 512'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_valids", 512'({bus.axi_awvalid, bus.axi_wvalid, bus.axi_arvalid,
                                    bus.axi_bready, bus.axi_rready, bus.rsp_valid}), 512'(0));
        chk("mid_rst_req_ready", 512'(bus.req_ready), 512'(0));
        void'(sb.pop_back());
        exp_wr = 0;
        exp_rd = 0;
        w_hold_b1 = 0;
        repeat (2) @(negedge clk);
        chk("mid_rst_cnts", 512'({bus.wr_done_cnt, bus.rd_done_cnt}), 512'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("req_ready_after_mid_rst", 512'(bus.req_ready), 512'(1));
        repeat (3) begin
            @(negedge clk);
            chk("no_rsp_after_rst", 512'(bus.rsp_valid), 512'(0));
        end

        // recovery read
        send_req(1'b0, 64'h1000_0040, '0, '0, 1'b0);
        get_rsp(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/hawk_axi_line_mst.md
HAWK_AXI_LINE_MST -- requirements
Module: hawk_axi_line_mst

Interface
REQ-001 SHALL have parameter ID_W, default 6, AXI ID width.
REQ-002 SHALL have parameter MST_ID, default 6'd1, ID driven on awid/arid.
REQ-003 SHALL have clk  input  1  single clock; all logic on posedge clk.
REQ-004 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have req_valid/req_ready  input/output  1/1  line-request handshake.
REQ-006 SHALL have req_wr  input  1  1=write line, 0=read line.
REQ-007 SHALL have req_addr  input  64  byte address; bits [5:0] ignored.
REQ-008 SHALL have req_wdata/req_wstrb  input  512/64  write line and byte enables.
REQ-009 SHALL have rsp_valid/rsp_ready  output/input  1/1  completion handshake.
REQ-010 SHALL have rsp_rdata/rsp_err  output  512/1  read line; error flag.
REQ-011 SHALL have axi_awid/awaddr/awlen/awsize/awburst/awvalid  output  ID_W/64/8/3/2/1; axi_awready input 1.
REQ-012 SHALL have axi_wdata/wstrb/wlast/wvalid  output  256/32/1/1; axi_wready input 1.
REQ-013 SHALL have axi_bid/bresp/buser/bvalid  input  ID_W/2/1/1; axi_bready output 1.
REQ-014 SHALL have axi_arid/araddr/arlen/arsize/arburst/arvalid  output  ID_W/64/8/3/2/1; axi_arready input 1.
REQ-015 SHALL have axi_rid/rdata/rresp/ruser/rlast/rvalid  input  ID_W/256/2/1/1/1; axi_rready output 1.
REQ-016 SHALL have wr_done_cnt/rd_done_cnt  output  16/16  completed-transaction counters.

Function
REQ-017 SHALL run FSM IDLE, AW, W, B, AR, R, RSP; one transaction outstanding at most.
REQ-018 SHALL assert req_ready only in IDLE; req_valid&req_ready captures req_* into registers, next state AW (req_wr=1) or AR (req_wr=0).
REQ-019 SHALL drive addr {req_addr[63:6],6'b0}, len 8'd1, size 3'b101, burst 2'b01, id MST_ID on AW and AR.
REQ-020 SHALL hold awvalid high in AW until awready sampled high; then W. AW always precedes W; no W before AW acceptance.
REQ-021 SHALL in W send beat0 = wdata[255:0]/wstrb[31:0], then beat1 = wdata[511:256]/wstrb[63:32] with wlast=1; a beat advances only on wvalid&wready; data/strb stable while wvalid&!wready.
REQ-022 SHALL assert bready only in B; bvalid&bready ends write; err = (bresp!=0)|(bid!=MST_ID); next RSP.
REQ-023 SHALL hold arvalid in AR until arready; then R with rready=1.
REQ-024 SHALL in R store beat0 to rsp_rdata[255:0], beat1 to [511:256]; complete on second accepted beat; err |= rresp!=0 | rid!=MST_ID | rlast!=(beat==1).
REQ-025 SHALL ignore ruser and buser.
REQ-026 SHALL in RSP hold rsp_valid, rsp_rdata, rsp_err stable until rsp_ready; then IDLE; rsp_rdata is 0 for writes.
REQ-027 SHALL increment wr_done_cnt/rd_done_cnt on rsp handshake for write/read, saturating at 16'hFFFF, regardless of rsp_err.
REQ-028 SHALL add no latency beyond one cycle per FSM transition: request accept to awvalid/arvalid is 1 cycle.
REQ-029 SHALL never deassert a valid before its ready, nor change payload while valid&!ready.

Reset
REQ-030 SHALL on rst force IDLE, all AXI valids, bready, rready, rsp_valid, rsp_err low, req_ready low, counters and captured data zero.
REQ-031 SHALL raise req_ready on the first posedge after rst deassertion.
REQ-032 SHALL abandon any in-flight transaction on rst with no response issued.

Verification
REQ-033 Write 0x1000_0040 with data pattern, strb all ones, slave ready always -> awaddr 0x1000_0040, awlen 1, two W beats, wlast on beat1, rsp_err 0, wr_done_cnt 1.
REQ-034 Read back 0x1000_0040 -> arlen 1, rsp_rdata equals written 512-bit line, rsp_err 0, rd_done_cnt 1.
REQ-035 Write with awready low 5 cycles and wready toggling -> awvalid held 5 cycles, no W before AW accept, data stable during stalls.
REQ-036 Read with rresp=2'b10 on beat1 or rlast on beat0 -> rsp_err 1, counters still increment.
REQ-037 bid=MST_ID+1 on write -> rsp_err 1; rsp_ready low 3 cycles -> rsp_valid/data stable 3 cycles.
REQ-038 rst asserted mid W beat1 -> all valids low immediately, FSM IDLE, req_ready 1 cycle after release, no rsp_valid.
